// File: rtl/qgate_1q_pipelined.sv
// qgate_1q_pipelined: three-stage single-qubit gate (route/add, scale, round/saturate)
// applying I/X/Y/Z/H/S/T/Tdg to a fixed-point amplitude pair with valid/ready flow control.
module qgate_1q_pipelined #(
    parameter int W    = 8,
    parameter int FRAC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] alpha_r,
    input  logic [W-1:0] alpha_i,
    input  logic [W-1:0] beta_r,
    input  logic [W-1:0] beta_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] new_alpha_r,
    output logic [W-1:0] new_alpha_i,
    output logic [W-1:0] new_beta_r,
    output logic [W-1:0] new_beta_i,
    output logic         out_sat,
    output logic         sat_sticky,
    input  logic         sat_clear
);
    // round(2^f/sqrt2) == round(sqrt(2^(2f-1))), found as the largest c with (2c-1)^2 <= 4x
    function automatic int round_inv_sqrt2(input int f);
        longint x4;
        int c;
        x4 = longint'(1) << (2 * f + 1);
        c = 0;
        while (longint'(2 * c + 1) * longint'(2 * c + 1) <= x4) c++;
        return c;
    endfunction

    localparam int C = round_inv_sqrt2(FRAC);
    localparam int P = 2 * W + 1;
    localparam logic signed [P-1:0] CW   = P'(C);
    localparam logic signed [P-1:0] HALF = P'(1 << (FRAC - 1));
    localparam logic signed [P-1:0] MAXV = P'((1 << (W - 1)) - 1);
    localparam logic signed [P-1:0] MINV = P'(-(1 << (W - 1)));

    function automatic logic signed [P-1:0] scale(input logic signed [W:0] s, input logic k);
        logic signed [P-1:0] sx;
        sx = {{W{s[W]}}, s};
        return k ? sx * CW : sx <<< FRAC;
    endfunction

    // returns {clamped, value}
    function automatic logic [W:0] rnd_sat(input logic signed [P-1:0] p);
        logic signed [P-1:0] q;
        q = (p + HALF) >>> FRAC;
        return q > MAXV ? {1'b1, MAXV[W-1:0]} : q < MINV ? {1'b1, MINV[W-1:0]} : {1'b0, q[W-1:0]};
    endfunction

    logic signed [W:0] ar, ai, br, bi, s_ar, s_ai, s_br, s_bi;
    logic signed [W:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [P-1:0] p_ar, p_ai, p_br, p_bi;
    logic [W:0] q_ar, q_ai, q_br, q_bi;
    logic scl_a, scl_b, s1_sa, s1_sb, v1, v2;

    assign ar = {alpha_r[W-1], alpha_r};
    assign ai = {alpha_i[W-1], alpha_i};
    assign br = {beta_r[W-1], beta_r};
    assign bi = {beta_i[W-1], beta_i};
    assign scl_a = op == 3'd4;
    assign scl_b = op == 3'd4 || op[2:1] == 2'b11;
    assign in_ready = !(out_valid && !out_ready);

    always_comb begin
        {s_ar, s_ai, s_br, s_bi} = {ar, ai, br, bi};
        case (op)
            3'd1: {s_ar, s_ai, s_br, s_bi} = {br, bi, ar, ai};
            3'd2: {s_ar, s_ai, s_br, s_bi} = {bi, -br, -ai, ar};
            3'd3: {s_br, s_bi} = {-br, -bi};
            3'd4: {s_ar, s_ai, s_br, s_bi} = {ar + br, ai + bi, ar - br, ai - bi};
            3'd5: {s_br, s_bi} = {-bi, br};
            3'd6: {s_br, s_bi} = {br - bi, br + bi};
            3'd7: {s_br, s_bi} = {br + bi, bi - br};
            default: ;
        endcase
    end

    assign q_ar = rnd_sat(p_ar);
    assign q_ai = rnd_sat(p_ai);
    assign q_br = rnd_sat(p_br);
    assign q_bi = rnd_sat(p_bi);

    // a single enable freezes every stage while the output is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, out_valid, s1_sa, s1_sb, out_sat} <= '0;
            {s1_ar, s1_ai, s1_br, s1_bi} <= '0;
            {p_ar, p_ai, p_br, p_bi} <= '0;
            {new_alpha_r, new_alpha_i, new_beta_r, new_beta_i} <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            v2 <= v1;
            out_valid <= v2;
            if (in_valid)
                {s1_ar, s1_ai, s1_br, s1_bi, s1_sa, s1_sb} <= {s_ar, s_ai, s_br, s_bi, scl_a, scl_b};
            if (v1) begin
                p_ar <= scale(s1_ar, s1_sa);
                p_ai <= scale(s1_ai, s1_sa);
                p_br <= scale(s1_br, s1_sb);
                p_bi <= scale(s1_bi, s1_sb);
            end
            if (v2) begin
                {new_alpha_r, new_alpha_i, new_beta_r, new_beta_i} <= {q_ar[W-1:0], q_ai[W-1:0], q_br[W-1:0], q_bi[W-1:0]};
                out_sat <= q_ar[W] | q_ai[W] | q_br[W] | q_bi[W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_sticky <= 1'b0;
        else if (sat_clear)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && out_sat)
            sat_sticky <= 1'b1;
    end
endmodule

// File: doc/qgate_1q_pipelined.md
# qgate_1q_pipelined

Parametrised, pipelined single-qubit gate unit for the QFT datapath. Applies one of eight fixed 2×2 unitaries (I, X, Y, Z, H, S, T, T†) to a complex amplitude pair (alpha, beta) held in signed fixed point. Generalises the Hadamard-only pipelined gate:
- configurable width and fraction bits;
- per-transaction gate select;
- valid/ready flow control with stall;
- round-half-up rounding;
- saturation with per-result and sticky overflow flags.

## Interface
Parameters:
- W, default 8: total signed width of every amplitude component; W ≥ 4.
- FRAC, default 4: fraction bits; 1 ≤ FRAC ≤ W-2.
- C: derived localparam, not overridable. C = round(2^FRAC/√2) = 11 for FRAC=4.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input pair and op are valid.
- in_ready  out  1  unit accepts input this cycle.
- op  in  3  gate select: 0 I, 1 X, 2 Y, 3 Z, 4 H, 5 S, 6 T, 7 T†.
- alpha_r, alpha_i, beta_r, beta_i  in  W each  input amplitudes, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- new_alpha_r, new_alpha_i, new_beta_r, new_beta_i  out  W each  result amplitudes, signed.
- out_sat  out  1  at least one component of this result was saturated.
- sat_sticky  out  1  OR of out_sat over all accepted results since reset or clear.
- sat_clear  in  1  synchronous clear of sat_sticky.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- op is captured with the data and travels with it, so mixed ops back-to-back are legal.
- Stage 1 (route/add), exact in W+1 bits. Each output component is one scaled term s and a flag scaled:

| op | new_alpha | new_beta | scaled |
|---|---|---|---|
| I | a | b | no |
| X | b | a | no |
| Y | (b_i, -b_r) | (-a_i, a_r) | no |
| Z | a | (-b_r, -b_i) | no |
| H | a+b | a-b | yes |
| S | a | (-b_i, b_r) | no |
| T | a | (b_r-b_i, b_r+b_i) | yes |
| T† | a | (b_r+b_i, b_i-b_r) | yes |

- Stage 2 (scale): p = s·C if scaled, else p = s·2^FRAC (shift). The product is held in 2W+1 bits, so there is no overflow.
- Stage 3 (round/saturate):
  - q = (p + 2^(FRAC-1)) >>> FRAC, an arithmetic shift, so ties round toward +∞.
  - Clamp q to [-2^(W-1), 2^(W-1)-1].
  - out_sat = OR of the four clamp events.
- Unscaled ops are exact except negation of -2^(W-1), which saturates to 2^(W-1)-1 and sets out_sat.
- sat_sticky:
  - Set in the cycle a result with out_sat=1 is transferred out.
  - sat_clear has priority over a same-cycle set.

## Timing
- Latency is exactly 3 cycles from input transfer to out_valid when no stall occurs. Throughput is 1 pair per cycle.
- Stall = out_valid && !out_ready.
  - While stalled, every stage register and valid bit holds.
  - Outputs stay stable and in_ready = 0.
  - in_ready = !stall is combinational from out_ready and out_valid.
- Bubbles (in_valid=0) propagate as valid=0 slots. When stage 3 is empty, the pipeline advances even if out_ready=0.
- Reset (asserted at any time, including mid-stream):
  - All valid bits and data registers clear to 0.
  - Outputs: out_valid=0, all new_* = 0, out_sat=0, sat_stick=0.
  - In-flight transactions are discarded.
  - in_ready = 1 after reset.
- Data outputs change only on a cycle where stage 3 loads.

## Test plan
- H basis: op=4, alpha=(16,0), beta=(0,0) → 3 cycles later new_alpha=(11,0), new_beta=(11,0), out_sat=0.
- H saturation: op=4, alpha=(127,0), beta=(127,0) → new_alpha=(127,0) (254·11 rounds to 175, clamped), new_beta=(0,0), out_sat=1, sat_sticky=1. Then sat_clear → sat_sticky=0.
- Rounding and T: op=6, alpha=(5,-3), beta=(16,0) → new_alpha=(5,-3), new_beta=(11,11). With beta=(-16,0) → new_beta=(-11,-11), confirming the floor after the +8 bias.
- Exact ops streamed back-to-back, one per cycle (X, Y, Z, S, I) with alpha=(3,-4), beta=(-7,2):
  - X → α=(-7,2), β=(3,-4)
  - Y → α=(2,7), β=(4,3)
  - Z → β=(7,-2)
  - S → β=(-2,-7)
  - I → unchanged
  - Expect 5 consecutive out_valid cycles.
- Z edge: op=3, beta=(-128,-128) → new_beta=(127,127), out_sat=1.
- Backpressure and reset:
  - Stream 6 pairs, hold out_ready=0 for 4 cycles once out_valid rises. Check in_ready=0, outputs frozen, no loss or duplication, order preserved on release.
  - Assert rst_n=0 mid-stream. Check out_valid=0 and outputs 0 immediately (asynchronous). No stale result after release.
